// File: rtl/tse_ahb_pkg.sv
`default_nettype none
// tse_ahb_pkg: AHB-Lite codes, slave FSM state type and byte-lane decode.
// Revision: 1.0
package tse_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RESP = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tse_ahb_bram_1rw.sv
`default_nettype none
// tse_ahb_bram_1rw: 32-bit single-port RAM, byte write enables, synchronous read.
// Revision: 1.0
module tse_ahb_bram_1rw #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/tse_ahb_dma_mem_slave.sv
`default_nettype none
// tse_ahb_dma_mem_slave: AHB-Lite packet-buffer slave with wait states and two-cycle ERROR.
// Revision: 1.0
module tse_ahb_dma_mem_slave
    import tse_ahb_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW = ADDR_BITS - 2;

    ahb_state_e    state_q, state_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [3:0]    strb_q;
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;
    logic [31:0]   pend_data_q;
    logic [3:0]    pend_strb_q;
    logic [31:0]   hrdata_q;

    logic          trans_active, capture, addr_err, rd_fetch, wr_commit;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata, ram_rdata, rd_merged;
    logic          unused_ok;

    assign unused_ok = &{1'b0, HBURST};

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state_q == ST_RESP && !write_q) ? rd_merged : hrdata_q;

    always_comb begin
        trans_active = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase
    end

    assign capture = HSEL && HREADY && trans_active && HREADYOUT;

    always_comb begin
        addr_err = (HADDR[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) || (HSIZE > HSIZE_WORD);
        if (HSIZE == HSIZE_HALF && HADDR[0]) addr_err = 1'b1;
        if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 2'd1) state_d = ST_RESP;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, RESP and ERR2 all accept a new address phase
                if (!capture)              state_d = ST_IDLE;
                else if (addr_err)         state_d = ST_ERR1;
                else if (WAIT_STATES == 0) state_d = ST_RESP;
                else begin
                    state_d = ST_WAIT;
                    wcnt_d  = 2'(WAIT_STATES);
                end
            end
        endcase
    end

    // The single RAM port is owned by a read fetch on the edge before its RESP;
    // a write that collides with it is parked and forwarded until the port frees up.
    assign rd_fetch  = (capture && !addr_err && !HWRITE && WAIT_STATES == 0) ||
                       (state_q == ST_WAIT && !write_q && wcnt_q == 2'd1);
    assign wr_commit = (state_q == ST_RESP) && write_q;

    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 4'b0000;
        ram_wdata = HWDATA;
        if (rd_fetch) begin
            ram_addr = (state_q == ST_WAIT) ? addr_q : HADDR[ADDR_BITS-1:2];
        end else if (pend_q) begin
            ram_addr  = pend_addr_q;
            ram_we    = pend_strb_q;
            ram_wdata = pend_data_q;
        end else if (wr_commit) begin
            ram_we = strb_q;
        end
    end

    always_comb begin
        rd_merged = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (pend_q && pend_addr_q == addr_q && pend_strb_q[i]) begin
                rd_merged[8*i +: 8] = pend_data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 2'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            strb_q      <= 4'b0000;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= 32'd0;
            pend_strb_q <= 4'b0000;
            hrdata_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (capture) begin
                addr_q  <= HADDR[ADDR_BITS-1:2];
                write_q <= HWRITE;
                strb_q  <= byte_strobe(HSIZE, HADDR[1:0]);
            end
            if (state_q == ST_RESP && !write_q) begin
                hrdata_q <= rd_merged;
            end
            if (wr_commit && (rd_fetch || pend_q)) begin
                pend_q      <= 1'b1;
                pend_addr_q <= addr_q;
                pend_data_q <= HWDATA;
                pend_strb_q <= strb_q;
            end else if (!rd_fetch) begin
                pend_q <= 1'b0;
            end
        end
    end

    tse_ahb_bram_1rw #(.AW(AW)) u_ram (
        .clk_i   (HCLK),
        .re_i    (rd_fetch),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_tse_ahb_dma_mem_slave.sv
`default_nettype none
// tb_tse_ahb_dma_mem_slave: directed bench, instance 0 with one wait state, instance 1 with none.
module tb_tse_ahb_dma_mem_slave;
    import tse_ahb_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic [1:0]  hresp     [2];
    logic [31:0] hrdata    [2];

    int          checks = 0;
    int          errors = 0;
    int          x_waits;
    logic [1:0]  x_resp, lo_resp;
    logic [31:0] x_rdata;

    always #5 clk = ~clk;

    tse_ahb_dma_mem_slave #(.WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    tse_ahb_dma_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input int d, input logic [31:0] a, input logic w,
                              input logic [2:0] sz, input logic [1:0] tr);
        hsel[d]   = 1'b1;
        haddr[d]  = a;
        hwrite[d] = w;
        hsize[d]  = sz;
        htrans[d] = tr;
    endtask

    // Single non-pipelined transfer; the data phase is walked with a bounded wait
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd);
        int n;
        addr_phase(d, a, w, sz, HTRANS_NONSEQ);
        step();
        htrans[d] = HTRANS_IDLE;
        hwdata[d] = wd;
        n = 0;
        lo_resp = 2'b11;
        while (hreadyout[d] !== 1'b1 && n < 8) begin
            if (n == 0) lo_resp = hresp[d];
            n++;
            step();
        end
        x_waits = n;
        x_resp  = hresp[d];
        x_rdata = hrdata[d];
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
            hsize[d] = HSIZE_WORD; hburst[d] = 3'b000; hwdata[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_hreadyout_ws1", hreadyout[0], 1);
        check("rst_hresp_ws1", hresp[0], 0);
        check("rst_hrdata_ws1", hrdata[0], 0);
        check("rst_hreadyout_ws0", hreadyout[1], 1);
        check("rst_hrdata_ws0", hrdata[1], 0);
        hresetn = 1'b1;
        step();

        // Word write then read with one wait state
        xfer(0, BASE + 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        check("wr10_waits", x_waits, 1);
        check("wr10_resp", x_resp, 0);
        xfer(0, BASE + 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        check("rd10_waits", x_waits, 1);
        check("rd10_resp", x_resp, 0);
        check("rd10_data", x_rdata, 32'hDEADBEEF);

        // Byte and halfword lane merge
        xfer(0, BASE + 32'h20, 1'b1, HSIZE_WORD, 32'h55667788);
        xfer(0, BASE + 32'h21, 1'b1, HSIZE_BYTE, 32'h0000AA00);
        xfer(0, BASE + 32'h22, 1'b1, HSIZE_HALF, 32'h12340000);
        xfer(0, BASE + 32'h20, 1'b0, HSIZE_WORD, 32'h0);
        check("rd20_merge", x_rdata, 32'h1234AA88);

        // Out-of-window access: two-cycle ERROR, errored write leaves memory alone
        xfer(0, BASE + 32'h0, 1'b1, HSIZE_WORD, 32'hCAFEF00D);
        xfer(0, 32'h3000_0000, 1'b0, HSIZE_WORD, 32'h0);
        check("oow_rd_err1_cycles", x_waits, 1);
        check("oow_rd_err1_resp", lo_resp, 1);
        check("oow_rd_err2_resp", x_resp, 1);
        xfer(0, 32'h3000_0000, 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        check("oow_wr_resp", x_resp, 1);
        xfer(0, BASE + 32'h0, 1'b0, HSIZE_WORD, 32'h0);
        check("rd0_unchanged", x_rdata, 32'hCAFEF00D);

        // Misaligned word read errors; next NONSEQ is a normal OKAY
        xfer(0, BASE + 32'h2, 1'b0, HSIZE_WORD, 32'h0);
        check("misalign_err1_resp", lo_resp, 1);
        check("misalign_err2_resp", x_resp, 1);
        xfer(0, BASE + 32'h4, 1'b1, HSIZE_WORD, 32'h0BADC0DE);
        check("after_err_wr_waits", x_waits, 1);
        check("after_err_wr_resp", x_resp, 0);
        xfer(0, BASE + 32'h4, 1'b0, HSIZE_WORD, 32'h0);
        check("rd4_data", x_rdata, 32'h0BADC0DE);
        xfer(0, BASE + 32'h0, 1'b0, 3'b011, 32'h0);
        check("bad_size_resp", x_resp, 1);

        // Zero-wait INCR4 write burst with a BUSY, then back-to-back reads
        hburst[1] = 3'b011;
        addr_phase(1, BASE + 32'h40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        hwdata[1] = 32'h11111111;
        addr_phase(1, BASE + 32'h44, 1'b1, HSIZE_WORD, HTRANS_BUSY);
        check("b0_hreadyout", hreadyout[1], 1);
        step();
        check("busy_hreadyout", hreadyout[1], 1);
        check("busy_hresp", hresp[1], 0);
        hwdata[1] = 32'hFFFFFFFF;
        addr_phase(1, BASE + 32'h44, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        step();
        hwdata[1] = 32'h22222222;
        addr_phase(1, BASE + 32'h48, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        check("b1_hreadyout", hreadyout[1], 1);
        step();
        hwdata[1] = 32'h33333333;
        addr_phase(1, BASE + 32'h4C, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        check("b2_hreadyout", hreadyout[1], 1);
        step();
        hwdata[1] = 32'h44444444;
        addr_phase(1, BASE + 32'h4C, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        check("b3_hreadyout", hreadyout[1], 1);
        step();
        addr_phase(1, BASE + 32'h40, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        check("rd4c_fwd_ready", hreadyout[1], 1);
        check("rd4c_fwd_data", hrdata[1], 32'h44444444);
        step();
        addr_phase(1, BASE + 32'h44, 1'b0, HSIZE_WORD, HTRANS_SEQ);
        check("rd40_data", hrdata[1], 32'h11111111);
        step();
        addr_phase(1, BASE + 32'h48, 1'b0, HSIZE_WORD, HTRANS_SEQ);
        check("rd44_data", hrdata[1], 32'h22222222);
        step();
        htrans[1] = HTRANS_IDLE;
        check("rd48_data", hrdata[1], 32'h33333333);
        check("rd48_resp", hresp[1], 0);
        step();
        check("idle_holds_rdata", hrdata[1], 32'h33333333);

        // Asynchronous reset in the middle of a WAIT data phase
        addr_phase(0, BASE + 32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step();
        htrans[0] = HTRANS_IDLE;
        check("pre_rst_wait", hreadyout[0], 0);
        check("pre_rst_rdata_hold", hrdata[0], 32'h0BADC0DE);
        #1;
        hresetn = 1'b0;
        #1;
        check("async_rst_hreadyout", hreadyout[0], 1);
        check("async_rst_hresp", hresp[0], 0);
        check("async_rst_hrdata", hrdata[0], 0);
        step();
        hresetn = 1'b1;
        step();
        xfer(0, BASE + 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        check("post_rst_waits", x_waits, 1);
        check("post_rst_data", x_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
